pvr_ddram_arbiter: RTL and testbench
====================================

Name: pvr_ddram_arbiter

Overview:
- Shares the single PVR DDRAM burst-read port between NUM_REQ requesters: param cache, texture fetch and region-array/list walker.
- Each requester issues a fixed-length burst read request. The block round-robin arbitrates, drives the DDRAM command, and routes the returned words back to the winning requester.
- It sits between the PVR fetch clients and the DDRAM Avalon-style master.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BURST_LEN, 32, words per burst (2..64).
- CNT_W, 6, word counter width; must satisfy 2**CNT_W >= BURST_LEN.

Ports:
- clock  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request; level, held until req_ack.
- req_addr  in  NUM_REQ*22  packed word addresses; slice i = [22*i+21:22*i]; stable while req_read[i] is high.
- req_ack  out  NUM_REQ  one-cycle pulse when requester i's command is accepted by DDRAM.
- rd_data  out  32  returned word, shared by all requesters.
- rd_valid  out  NUM_REQ  one-hot; rd_data is valid for requester i.
- rd_last  out  NUM_REQ  one-hot; coincides with the final rd_valid of a burst.
- ddram_waitrequest  in  1  DDRAM command stall.
- ddram_addr  out  22  burst start address.
- ddram_burstcnt  out  CNT_W+1  constant BURST_LEN.
- ddram_read_burst  out  1  read command.
- ddram_readdata  in  32  DDRAM read data.
- ddram_readdata_valid  in  1  DDRAM read data strobe.
- busy  out  1  high whenever state is not IDLE.
- protocol_err  out  1  sticky; set on a stray readdata_valid.

Behaviour:
- Reset values: all outputs 0 (except ddram_burstcnt = BURST_LEN). state=IDLE, grant=0, word_cnt=0, last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset mid-burst aborts immediately. Any words still in flight from DDRAM after reset are stray and set protocol_err.
- All outputs are registered.
- States: IDLE, ISSUE, DATA.
- IDLE, when any req_read bit is high:
  - Pick the first set bit searching from last_grant+1 upward, modulo NUM_REQ.
  - Latch grant; ddram_addr <= req_addr[grant]; ddram_read_burst <= 1; word_cnt <= 0; go to ISSUE.
  - If no bit is high, stay in IDLE.
- ISSUE:
  - Hold ddram_read_burst=1 and ddram_addr until a cycle where ddram_waitrequest=0. That cycle is command acceptance.
  - On acceptance: ddram_read_burst <= 0, req_ack[grant] <= 1 for one cycle, go to DATA.
  - If req_read[grant] drops during ISSUE, it is ignored; the burst completes and its data is still delivered.
- DATA:
  - On each ddram_readdata_valid: rd_data <= ddram_readdata, rd_valid <= onehot(grant), word_cnt <= word_cnt+1. Response latency is 1 cycle.
  - When the valid arrives with word_cnt == BURST_LEN-1: also rd_last <= onehot(grant), last_grant <= grant, go to IDLE.
  - rd_valid and rd_last pulse only on cycles with an incoming valid. Gaps in valid are tolerated, with no timeout.
- Readdata_valid arriving in IDLE or ISSUE: the data is dropped, protocol_err <= 1. protocol_err clears only on reset.
- A valid in the same cycle as acceptance in ISSUE is also stray, since DDRAM returns data strictly after acceptance.
- Back-to-back bursts:
  - The earliest new arbitration is the cycle after rd_last, i.e. while in IDLE.
  - The minimum gap is therefore 1 IDLE cycle between the last valid and the next ddram_read_burst.
- Requester i must not reassert req_read before it sees its rd_last. A request raised during another requester's burst waits in IDLE arbitration.
- Fairness: with all requesters held high, grants rotate 0,1,2,0,...

Decomposition:
- Package pvr_mem_pkg:
  - PVR_ADDR_W=22, PVR_DATA_W=32.
  - State enum arb_state_t {IDLE, ISSUE, DATA}.
  - Function onehot(idx).
- Sub-module rr_pick (combinational rotate-priority encoder). Inputs: req vector and last_grant. Outputs: any and grant index. Reused by later PVR write arbiters.

Test Plan:
- Single request: req_read=3'b001, addr0=22'h012340, waitrequest low → ddram_read_burst for exactly 1 cycle with addr 22'h012340, req_ack[0] pulse, 32 rd_valid[0] pulses with data echoed 1 cycle late, rd_last[0] on the 32nd, then busy=0.
- Waitrequest stall: waitrequest high for 5 cycles after the burst is raised → ddram_addr and read_burst held for 6 cycles total, req_ack[1] exactly once, on the acceptance cycle.
- Round-robin: req_read=3'b111 held → ddram_addr sequence addr0, addr1, addr2, addr0; no requester is granted twice in a row.
- Gapped data: valid toggles every other cycle for 32 words → word_cnt reaches 32 and rd_last is asserted only on the 32nd valid; rd_valid count = 32.
- Stray data: valid pulsed in IDLE with data 32'hDEADBEEF → no rd_valid, protocol_err=1 and sticky through the next good burst.
- Reset mid-burst: assert reset after word 10 of a requester-2 burst → all outputs 0 asynchronously; after release, requester 0 wins the first arbitration even if requests 0 and 2 are both pending.

Source files
------------

// File: rtl/pvr_mem_pkg.sv
// pvr_mem_pkg: shared PVR memory widths, arbiter state type and one-hot helper
package pvr_mem_pkg;
  localparam int PVR_ADDR_W = 22;
  localparam int PVR_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, DATA} arb_state_t;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction
endpackage

// File: rtl/pvr_ddram_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set req bit searching upward from last_i+1
// Ports: req_i request vector, last_i previous grant, any_o some request set, grant_o winner index
module rr_pick #(
  parameter int N = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             any_o,
  output logic [IDX_W-1:0] grant_o
);
  int j;
  always_comb begin
    any_o = |req_i;
    grant_o = '0;
    j = 0;
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (req_i[j]) grant_o = IDX_W'(j);
    end
  end
endmodule

// File: rtl/pvr_ddram_arbiter.sv
// pvr_ddram_arbiter: round-robin share of the PVR DDRAM burst-read port among NUM_REQ clients
// Ports: req_read_i/req_addr_i client requests, req_ack_o/rd_*_o client responses,
// ddram_* Avalon-style burst master, busy_o not idle, protocol_err_o sticky stray-data flag
module pvr_ddram_arbiter
  import pvr_mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int BURST_LEN = 32,
  parameter int CNT_W = 6
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_read_i,
  input  logic [NUM_REQ*PVR_ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]           req_ack_o,
  output logic [PVR_DATA_W-1:0]        rd_data_o,
  output logic [NUM_REQ-1:0]           rd_valid_o,
  output logic [NUM_REQ-1:0]           rd_last_o,
  input  logic                         ddram_waitrequest_i,
  output logic [PVR_ADDR_W-1:0]        ddram_addr_o,
  output logic [CNT_W:0]               ddram_burstcnt_o,
  output logic                         ddram_read_burst_o,
  input  logic [PVR_DATA_W-1:0]        ddram_readdata_i,
  input  logic                         ddram_readdata_valid_i,
  output logic                         busy_o,
  output logic                         protocol_err_o
);
  localparam int IDX_W = $clog2(NUM_REQ);
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, vld_q, vld_d, lst_q, lst_d, oh;
  logic [PVR_DATA_W-1:0] data_q, data_d;
  logic [PVR_ADDR_W-1:0] addr_q, addr_d;
  logic burst_q, burst_d, perr_q, perr_d, busy_q, any;
  rr_pick #(.N(NUM_REQ)) u_pick (.req_i(req_read_i), .last_i(last_q), .any_o(any), .grant_o(pick));
  assign oh = NUM_REQ'(onehot(3'(grant_q)));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    burst_d = burst_q;
    data_d = data_q;
    perr_d = perr_q;
    ack_d = '0;
    vld_d = '0;
    lst_d = '0;
    case (state_q)
      IDLE: begin
        perr_d = perr_q | ddram_readdata_valid_i;
        if (any) begin
          grant_d = pick;
          addr_d = req_addr_i[int'(pick)*PVR_ADDR_W +: PVR_ADDR_W];
          burst_d = 1'b1;
          cnt_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // DDRAM only returns data after acceptance, so any valid here is stray.
        perr_d = perr_q | ddram_readdata_valid_i;
        if (!ddram_waitrequest_i) begin
          burst_d = 1'b0;
          ack_d = oh;
          state_d = DATA;
        end
      end
      default: begin
        if (ddram_readdata_valid_i) begin
          data_d = ddram_readdata_i;
          vld_d = oh;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            lst_d = oh;
            last_d = grant_q;
            state_d = IDLE;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IDX_W'(NUM_REQ - 1);
      cnt_q <= '0;
      addr_q <= '0;
      burst_q <= 1'b0;
      data_q <= '0;
      perr_q <= 1'b0;
      ack_q <= '0;
      vld_q <= '0;
      lst_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      burst_q <= burst_d;
      data_q <= data_d;
      perr_q <= perr_d;
      ack_q <= ack_d;
      vld_q <= vld_d;
      lst_q <= lst_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign req_ack_o = ack_q;
  assign rd_data_o = data_q;
  assign rd_valid_o = vld_q;
  assign rd_last_o = lst_q;
  assign ddram_addr_o = addr_q;
  assign ddram_burstcnt_o = (CNT_W+1)'(BURST_LEN);
  assign ddram_read_burst_o = burst_q;
  assign busy_o = busy_q;
  assign protocol_err_o = perr_q;
endmodule

// File: tb/tb_pvr_ddram_arbiter.sv
// tb_pvr_ddram_arbiter: directed/random bench with a transaction-level arbiter model
module tb_pvr_ddram_arbiter;
  localparam int N = 3, BL = 32, CW = 6;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  logic [N-1:0] req_read = '0;
  logic [21:0] addr [N];
  logic [N*22-1:0] req_addr;
  logic [N-1:0] req_ack, rd_valid, rd_last;
  logic [31:0] rd_data, rdata = '0;
  logic waitreq = 0, valid = 0, rd_burst, busy, perr;
  logic [21:0] ddram_addr;
  logic [CW:0] burstcnt;
  int checks = 0, failures = 0, model_last = N - 1, win, prev;
  bit perr_exp = 0;
  always_comb for (int i = 0; i < N; i++) req_addr[22*i +: 22] = addr[i];

  pvr_ddram_arbiter #(.NUM_REQ(N), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clock_i(clock), .reset_i(reset), .req_read_i(req_read), .req_addr_i(req_addr),
    .req_ack_o(req_ack), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_last_o(rd_last),
    .ddram_waitrequest_i(waitreq), .ddram_addr_o(ddram_addr), .ddram_burstcnt_o(burstcnt),
    .ddram_read_burst_o(rd_burst), .ddram_readdata_i(rdata), .ddram_readdata_valid_i(valid),
    .busy_o(busy), .protocol_err_o(perr));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Round-robin rule: nearest requesting index after the previous winner, wrapping.
  function automatic int rr_model(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, req_ack, 0);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_last"}, rd_last, 0);
    check({tag, "_data"}, rd_data, 0);
    check({tag, "_addr"}, ddram_addr, 0);
    check({tag, "_burst"}, rd_burst, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_perr"}, perr, 0);
  endtask

  // gap: 0 none, 1 every other cycle, 2 random
  task automatic run_burst(input int stall, input int gap, input int max_words, input bit rearm, output int w);
    int n = 0;
    logic [31:0] d;
    logic [N-1:0] oh;
    w = rr_model(req_read, model_last);
    oh = (N)'(1) << w;
    while (!rd_burst && n < 8) begin
      tick;
      n++;
    end
    check("burst_start", rd_burst, 1);
    if (!rd_burst) return;
    check("cmd_addr", ddram_addr, addr[w]);
    check("busy_issue", busy, 1);
    waitreq = stall > 0;
    for (int s = 0; s < stall; s++) begin
      tick;
      check("stall_burst", rd_burst, 1);
      check("stall_addr", ddram_addr, addr[w]);
      check("stall_ack", req_ack, 0);
      if (s == stall - 1) waitreq = 0;
    end
    tick;
    check("accept_burst", rd_burst, 0);
    check("accept_ack", req_ack, oh);
    req_read[w] = 0;
    for (int k = 0; k < max_words; k++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
        valid = 0;
        tick;
        check("gap_valid", rd_valid, 0);
        check("gap_ack", req_ack, 0);
      end
      d = $urandom;
      valid = 1;
      rdata = d;
      tick;
      check("rd_valid", rd_valid, oh);
      check("rd_data", rd_data, d);
      check("rd_last", rd_last, k == BL - 1 ? oh : '0);
      check("data_busy", busy, k != BL - 1);
    end
    valid = 0;
    if (max_words < BL) return;
    check("perr_end", perr, perr_exp);
    model_last = w;
    if (rearm) req_read[w] = 1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) addr[i] = {i[1:0], 20'($urandom)};
    addr[0] = 22'h012340;
    repeat (2) tick;
    check_zero("reset");
    check("reset_burstcnt", burstcnt, BL);
    reset = 0;
    req_read = 3'b001;
    run_burst(0, 0, BL, 0, win);
    req_read = 3'b010;
    run_burst(5, 0, BL, 0, win);
    req_read = 3'b100;
    run_burst(0, 1, BL, 0, win);
    tick;
    valid = 1;
    rdata = 32'hDEADBEEF;
    tick;
    valid = 0;
    check("stray_valid", rd_valid, 0);
    check("stray_perr", perr, 1);
    perr_exp = 1;
    for (int r = 0; r < 3; r++) begin
      req_read = '0;
      req_read[$urandom_range(0, N - 1)] = 1;
      run_burst($urandom_range(0, 3), 2, BL, 0, win);
    end
    req_read = 3'b111;
    prev = model_last;
    for (int r = 0; r < 4; r++) begin
      run_burst(0, 2, BL, r != 3, win);
      check("rr_rotate", win, (prev + 1) % N);
      prev = win;
    end
    req_read = '0;
    tick;
    req_read = 3'b100;
    run_burst(0, 0, 10, 0, win);
    req_read = 3'b101;
    #2 reset = 1;
    #1 check_zero("async_reset");
    tick;
    reset = 0;
    model_last = N - 1;
    perr_exp = 0;
    run_burst(0, 0, BL, 0, win);
    check("post_reset_win0", win, 0);
    req_read = '0;
    tick;
    valid = 1;
    tick;
    valid = 0;
    check("late_stray_perr", perr, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
